// File: rtl/nn_act_pkg.sv
// Shared definitions for the activation datapath.
// act_mode_e is also driven by the layer sequencer, so the encoding is fixed:
//   ACT_RELU=0, ACT_LEAKY=1, ACT_CLIP=2, ACT_PASS=3.
package nn_act_pkg;

  typedef enum logic [1:0] {
    ACT_RELU  = 2'd0,
    ACT_LEAKY = 2'd1,
    ACT_CLIP  = 2'd2,
    ACT_PASS  = 2'd3
  } act_mode_e;

  // Default geometry of the activation stage.
  localparam int ACT_DIM_DEF        = 4;
  localparam int ACT_WIDTH_DEF      = 16;
  localparam int ACT_LEAK_SHIFT_DEF = 3;
  localparam int ACT_CNT_W_DEF      = 32;

endpackage

// File: rtl/act_lane.sv
// act_lane: combinational activation of one signed fixed-point element.
// Ports:
//   x      in  WIDTH  signed input element
//   mode   in  2      activation mode (act_mode_e)
//   clip   in  WIDTH  signed ceiling used by ACT_CLIP (negative ceiling acts as 0)
//   y      out WIDTH  activated element, never wider than the input
//   is_neg out 1      input element was negative
module act_lane
  import nn_act_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int LEAK_SHIFT = 3
) (
  input  logic signed [WIDTH-1:0] x,
  input  act_mode_e               mode,
  input  logic signed [WIDTH-1:0] clip,
  output logic signed [WIDTH-1:0] y,
  output logic                    is_neg
);

  logic signed [WIDTH-1:0] ceiling;

  always_comb begin
    ceiling = clip[WIDTH-1] ? '0 : clip;
    is_neg  = x[WIDTH-1];
    y       = x;
    case (mode)
      ACT_RELU: begin
        if (is_neg) y = '0;
      end
      ACT_LEAKY: begin
        // Arithmetic shift floors toward -inf, so -1 stays -1 and the
        // most-negative value still fits in WIDTH bits.
        if (is_neg) y = x >>> LEAK_SHIFT;
      end
      ACT_CLIP: begin
        if (is_neg)           y = '0;
        else if (x > ceiling) y = ceiling;
      end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/act_stream_unit.sv
// act_stream_unit: two-stage pipelined, lane-parallel activation with
// valid/ready flow control and a saturating negative-element counter.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready is independent of in_valid
//   in_vec              DIM signed lanes, lane i at [i*WIDTH +: WIDTH]
//   in_mode, in_clip    per-beat activation mode and clip ceiling
//   out_valid/out_ready output handshake
//   out_vec             activated lanes, held stable while stalled
//   stat_clr            synchronous clear of stat_neg_cnt (wins over increment)
//   stat_neg_cnt        saturating count of negative lanes in delivered beats
module act_stream_unit
  import nn_act_pkg::*;
#(
  parameter int DIM        = ACT_DIM_DEF,
  parameter int WIDTH      = ACT_WIDTH_DEF,
  parameter int LEAK_SHIFT = ACT_LEAK_SHIFT_DEF,
  parameter int CNT_W      = ACT_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DIM*WIDTH-1:0] in_vec,
  input  act_mode_e            in_mode,
  input  logic [WIDTH-1:0]     in_clip,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DIM*WIDTH-1:0] out_vec,
  input  logic                 stat_clr,
  output logic [CNT_W-1:0]     stat_neg_cnt
);

  localparam int PW = $clog2(DIM + 1);

  // Stage 1: raw beat
  logic                 s1_valid;
  logic [DIM*WIDTH-1:0] s1_vec;
  act_mode_e            s1_mode;
  logic [WIDTH-1:0]     s1_clip;

  // Stage 2: activated beat plus its negative-lane count
  logic                 s2_valid;
  logic [DIM*WIDTH-1:0] s2_vec;
  logic [PW-1:0]        s2_negs;

  logic                 s1_load;
  logic                 s2_load;
  logic                 deliver;

  logic [DIM*WIDTH-1:0] lane_y;
  logic [DIM-1:0]       lane_neg;
  logic [PW-1:0]        neg_pop;
  logic [CNT_W:0]       cnt_sum;
  logic [CNT_W-1:0]     cnt_sat;

  // A stage loads when it is empty or its occupant leaves this cycle.
  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign deliver   = s2_valid && out_ready;
  assign out_valid = s2_valid;
  assign out_vec   = s2_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_vec   <= '0;
      s1_mode  <= ACT_RELU;
      s1_clip  <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_vec  <= in_vec;
        s1_mode <= in_mode;
        s1_clip <= in_clip;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
      act_lane #(
        .WIDTH      (WIDTH),
        .LEAK_SHIFT (LEAK_SHIFT)
      ) u_lane (
        .x      (s1_vec[gi*WIDTH +: WIDTH]),
        .mode   (s1_mode),
        .clip   (s1_clip),
        .y      (lane_y[gi*WIDTH +: WIDTH]),
        .is_neg (lane_neg[gi])
      );
    end
  endgenerate

  always_comb begin
    neg_pop = '0;
    for (int i = 0; i < DIM; i++) begin
      neg_pop = neg_pop + PW'(lane_neg[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_vec   <= '0;
      s2_negs  <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_vec  <= lane_y;
        s2_negs <= neg_pop;
      end
    end
  end

  // One extra carry bit detects overflow; saturate instead of wrapping.
  always_comb begin
    cnt_sum = {1'b0, stat_neg_cnt} + (CNT_W+1)'(s2_negs);
    cnt_sat = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_neg_cnt <= '0;
    end else if (stat_clr) begin
      stat_neg_cnt <= '0;
    end else if (deliver) begin
      stat_neg_cnt <= cnt_sat;
    end
  end

endmodule

// File: tb/tb_act_stream_unit.sv
// Self-checking bench for act_stream_unit (DIM=4, WIDTH=16, LEAK_SHIFT=3,
// CNT_W=4 so saturation is reachable). Expected beats are queued when a
// beat is accepted and compared when the DUT delivers.
module tb_act_stream_unit;
  import nn_act_pkg::*;

  localparam int DIM   = 4;
  localparam int WIDTH = 16;
  localparam int LS    = 3;
  localparam int CNT_W = 4;
  localparam int VW    = DIM * WIDTH;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [VW-1:0]    in_vec = '0;
  act_mode_e        in_mode = ACT_RELU;
  logic [WIDTH-1:0] in_clip = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [VW-1:0]    out_vec;
  logic             stat_clr = 1'b0;
  logic [CNT_W-1:0] stat_neg_cnt;

  act_stream_unit #(
    .DIM(DIM), .WIDTH(WIDTH), .LEAK_SHIFT(LS), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_vec       (in_vec),
    .in_mode      (in_mode),
    .in_clip      (in_clip),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_vec      (out_vec),
    .stat_clr     (stat_clr),
    .stat_neg_cnt (stat_neg_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] vec;
    int            negs;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  int n_deliv = 0;
  int wait_cycles = 0;
  logic [VW-1:0] held = '0;
  bit stalled = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [VW-1:0] v;
    int   t;
    t = a; v[0*WIDTH +: WIDTH] = t[WIDTH-1:0];
    t = b; v[1*WIDTH +: WIDTH] = t[WIDTH-1:0];
    t = c; v[2*WIDTH +: WIDTH] = t[WIDTH-1:0];
    t = d; v[3*WIDTH +: WIDTH] = t[WIDTH-1:0];
    return v;
  endfunction

  function automatic int count_neg(input logic [VW-1:0] v);
    int n = 0;
    for (int i = 0; i < DIM; i++) begin
      if ($signed(v[i*WIDTH +: WIDTH]) < 0) n++;
    end
    return n;
  endfunction

  // Reference model in plain integer arithmetic (floor division for leaky).
  function automatic logic [VW-1:0] model_vec(input logic [VW-1:0] v, input act_mode_e m,
                                              input logic [WIDTH-1:0] c);
    logic [VW-1:0] res;
    int x, r, cl, cc;
    cl = $signed(c);
    for (int i = 0; i < DIM; i++) begin
      x = $signed(v[i*WIDTH +: WIDTH]);
      case (m)
        ACT_RELU:  r = (x < 0) ? 0 : x;
        ACT_LEAKY: r = (x < 0) ? (x - ((1 << LS) - 1)) / (1 << LS) : x;
        ACT_CLIP: begin
          cc = (cl < 0) ? 0 : cl;
          r  = (x < 0) ? 0 : ((x > cc) ? cc : x);
        end
        default:   r = x;
      endcase
      res[i*WIDTH +: WIDTH] = r[WIDTH-1:0];
    end
    return res;
  endfunction

  // Drive one beat, wait for acceptance (bounded), queue its expected output.
  task automatic send(input logic [VW-1:0] v, input act_mode_e m,
                      input logic [WIDTH-1:0] c, input logic [VW-1:0] e);
    exp_t item;
    int   w = 0;
    in_vec = v; in_mode = m; in_clip = c; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      wait_cycles++;
      if (w > 200) begin
        check("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    item.vec  = e;
    item.negs = count_neg(v);
    sb.push_back(item);
    $display("accept vec=%h mode=%0d clip=%0d", v, m, $signed(c));
    #1 in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [VW-1:0]    v;
    logic [WIDTH-1:0] c;
    act_mode_e        m;
    for (int i = 0; i < DIM; i++) begin
      case ($urandom_range(0, 5))
        0:       v[i*WIDTH +: WIDTH] = 16'h8000;
        1:       v[i*WIDTH +: WIDTH] = 16'hFFFF;
        2:       v[i*WIDTH +: WIDTH] = 16'h7FFF;
        default: v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      endcase
    end
    m = act_mode_e'($urandom_range(0, 3));
    c = WIDTH'($urandom_range(0, 2000)) - WIDTH'(500);
    send(v, m, c, model_vec(v, m, c));
  endtask

  task automatic clr_cnt();
    @(posedge clk); #1 stat_clr = 1'b1;
    @(posedge clk); #1 stat_clr = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Output monitor: scoreboard compare, stall stability, counter model.
  always @(negedge clk) begin
    exp_t e;
    int   negs;
    if (!rst_n) begin
      stalled = 0;
      exp_cnt = 0;
    end else begin
      negs = 0;
      check("stat_cnt", 64'(stat_neg_cnt), 64'(exp_cnt));
      if (stalled) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_vec", 64'(out_vec), 64'(held));
      end
      if (out_valid && out_ready) begin
        n_deliv++;
        $display("deliver #%0d vec=%h", n_deliv, out_vec);
        if (sb.size() == 0) begin
          check("spurious_beat", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          negs = e.negs;
          check("out_vec", 64'(out_vec), 64'(e.vec));
        end
      end
      if (stat_clr) exp_cnt = 0;
      else if (out_valid && out_ready) exp_cnt = (exp_cnt + negs > CMAX) ? CMAX : exp_cnt + negs;
      stalled = out_valid && !out_ready;
      held    = out_vec;
    end
  end

  initial begin
    int d0;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_vec", 64'(out_vec), 64'd0);
    check("rst_cnt", 64'(stat_neg_cnt), 64'd0);
    rst_n = 1'b1;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;

    // ReLU with latency check
    clr_cnt();
    send(pack4(-5, 0, 7, -32768), ACT_RELU, '0, pack4(0, 0, 7, 0));
    check("lat_cycle1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_cycle2", 64'(out_valid), 64'd1);
    repeat (3) @(posedge clk);
    #1 check("relu_cnt", 64'(stat_neg_cnt), 64'd2);

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(pack4(1, 2, 3, 4), ACT_PASS, '0, pack4(1, 2, 3, 4));
    send(pack4(-1, 5, 6, 7), ACT_PASS, '0, pack4(-1, 5, 6, 7));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_vec", 64'(out_vec), 64'd0);
    check("midrst_cnt", 64'(stat_neg_cnt), 64'd0);
    sb.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1 check("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (5) @(posedge clk);
    #1 check("midrst_no_stale", 64'(out_valid), 64'd0);

    // Leaky and clip, mode/clip changing beat to beat
    send(pack4(-16, -1, -32768, 100), ACT_LEAKY, '0, pack4(-2, -1, -4096, 100));
    send(pack4(-3, 6, 7, 32767), ACT_CLIP, 16'd6, pack4(0, 6, 6, 6));
    send(pack4(5, -1, 0, 2), ACT_CLIP, 16'hFFFC, pack4(0, 0, 0, 0));
    send(pack4(-7, 9, -32768, 3), ACT_RELU, 16'd6, pack4(0, 9, 0, 3));
    drain();

    // Full throughput: back-to-back beats with out_ready held high
    wait_cycles = 0;
    d0 = n_deliv;
    repeat (8) send_rand();
    check("tput_waits", 64'(wait_cycles), 64'd0);
    drain();
    check("tput_delivered", 64'(n_deliv - d0), 64'd8);

    // Backpressure: random out_ready including a 10-cycle stall
    d0 = n_deliv;
    fork
      begin
        repeat (20) send_rand();
      end
      begin
        for (int cyc = 0; cyc < 40; cyc++) begin
          @(posedge clk);
          #1 out_ready = (cyc >= 5 && cyc < 15) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();
    check("bp_delivered", 64'(n_deliv - d0), 64'd20);

    // Counter saturation and clear-beats-increment
    clr_cnt();
    repeat (5) send(pack4(-1, -2, -3, -32768), ACT_PASS, '0, pack4(-1, -2, -3, -32768));
    drain();
    check("cnt_saturated", 64'(stat_neg_cnt), 64'(CMAX));
    out_ready = 1'b0;
    send(pack4(-9, -8, 1, 2), ACT_RELU, '0, pack4(0, 0, 1, 2));
    @(posedge clk); #1;
    check("clr_pre_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    stat_clr  = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    check("clr_wins", 64'(stat_neg_cnt), 64'd0);
    check("clr_delivered", 64'(out_valid), 64'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
